cfg_entry_loader: RTL and testbench

Streaming configuration loader that sits directly upstream of the 167x16 table RAM's update port. It accepts configuration packets on an AXI-Stream slave, filters them by module ID, and packs 64-bit beats into 167-bit entries. It writes each entry to consecutive RAM addresses and can optionally read each entry back to verify it. It reports completion and error events to the control plane.

---
 rtl/cfg_pkg.sv | 51 +++++
 rtl/cfg_beat_packer.sv | 56 +++++
 rtl/cfg_entry_loader.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_cfg_entry_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration entry loader:
//   - table geometry (entry width, stream width, address width, beats/entry)
//   - header field offsets and widths
//   - loader FSM state encoding
//   - small helpers (saturating error counter increment, count clamp)
// -----------------------------------------------------------------------------
package cfg_pkg;

    localparam int CFG_ENTRY_W = 167;
    localparam int CFG_DATA_W  = 64;
    localparam int CFG_ADDR_W  = 4;

    // Number of stream beats needed to build one table entry (ceiling divide).
    function automatic int beats_for(input int entry_w, input int data_w);
        return (entry_w + data_w - 1) / data_w;
    endfunction

    localparam int CFG_BEATS = beats_for(CFG_ENTRY_W, CFG_DATA_W);

    // Header beat layout
    localparam int HDR_ID_LSB   = 0;
    localparam int HDR_ID_W     = 8;
    localparam int HDR_ADDR_LSB = 8;
    localparam int HDR_ADDR_W   = 4;
    localparam int HDR_CNT_LSB  = 12;
    localparam int HDR_CNT_W    = 5;

    localparam logic [HDR_CNT_W-1:0] MAX_COUNT = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_VRD   = 3'd3,
        ST_VCMP  = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    // Error counter increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // The table only holds 16 entries, so larger requests are limited to 16.
    function automatic logic [HDR_CNT_W-1:0] clamp_count(input logic [HDR_CNT_W-1:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

endpackage

// File: rtl/cfg_beat_packer.sv
// -----------------------------------------------------------------------------
// cfg_beat_packer
// Collects BEATS stream beats into one ENTRY_W-bit entry, little-endian:
// beat k lands in bits [DATA_W*k +: DATA_W]; bits above ENTRY_W-1 are dropped.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           restart packing (drops any partial entry)
//   i_beat_valid      i_beat is accepted this cycle
//   i_beat            stream data
//   o_last_beat       the beat accepted this cycle completes an entry
//   o_entry_valid     one-cycle pulse the cycle after an entry completes
//   o_entry           packed entry (held until the next beat or clear)
// -----------------------------------------------------------------------------
module cfg_beat_packer #(
    parameter int ENTRY_W = 167,
    parameter int DATA_W  = 64,
    parameter int BEATS   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_beat_valid,
    input  logic [DATA_W-1:0]  i_beat,
    output logic               o_last_beat,
    output logic               o_entry_valid,
    output logic [ENTRY_W-1:0] o_entry
);

    localparam int SHIFT_W = BEATS * DATA_W;
    localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [SHIFT_W-1:0] r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_entry_valid;

    assign o_last_beat   = i_beat_valid && (r_idx == LAST_IDX);
    assign o_entry_valid = r_entry_valid;
    assign o_entry       = r_shift[ENTRY_W-1:0];

    // Shift new beats in from the top so the first beat ends up at bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_shift       <= '0;
            r_idx         <= '0;
            r_entry_valid <= 1'b0;
        end else if (i_beat_valid) begin
            r_shift       <= {i_beat, r_shift[SHIFT_W-1:DATA_W]};
            r_idx         <= o_last_beat ? '0 : (r_idx + {{(IDX_W-1){1'b0}}, 1'b1});
            r_entry_valid <= o_last_beat;
        end else begin
            r_entry_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_entry_loader.sv
// -----------------------------------------------------------------------------
// cfg_entry_loader
// Streaming loader in front of the 16 x 167 table RAM update port. Accepts
// AXI-Stream configuration packets, keeps those addressed to MODULE_ID, packs
// 64-bit beats into 167-bit entries and writes them to consecutive addresses
// (mod 16) starting at the header's start address.
//
// Optional feature macro: CFG_LOADER_READBACK_EN
//   defined   - every write is read back (1-cycle RAM latency) and compared
//   undefined - ram_rd_en / ram_rd_addr tied to 0, ram_rd_data ignored
//
// Ports:
//   axis_clk, axis_rst          clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast   configuration stream in
//   s_axis_tready               loader ready (IDLE, FILL, DRAIN)
//   ram_wr_en/addr/data         RAM update port
//   ram_rd_en/addr, ram_rd_data RAM readback port
//   load_done                   pulse: packet completed without error
//   load_err                    pulse: truncated packet or verify mismatch
//   err_cnt                     saturating error count
// -----------------------------------------------------------------------------
module cfg_entry_loader
    import cfg_pkg::*;
#(
    parameter int         ENTRY_W   = CFG_ENTRY_W,
    parameter int         DATA_W    = CFG_DATA_W,
    parameter int         ADDR_W    = CFG_ADDR_W,
    parameter logic [7:0] MODULE_ID = 8'h00
) (
    input  logic               axis_clk,
    input  logic               axis_rst,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic               ram_wr_en,
    output logic [ADDR_W-1:0]  ram_wr_addr,
    output logic [ENTRY_W-1:0] ram_wr_data,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_rd_addr,
    input  logic [ENTRY_W-1:0] ram_rd_data,
    output logic               load_done,
    output logic               load_err,
    output logic [7:0]         err_cnt
);

    localparam int BEATS = beats_for(ENTRY_W, DATA_W);

    state_e                 r_state;
    state_e                 w_next_state;
    state_e                 w_post_state;

    logic [ADDR_W-1:0]      r_addr;
    logic [HDR_CNT_W-1:0]   r_remaining;
    logic                   r_last_seen;   // last completed entry's 3rd beat carried tlast
    logic                   r_no_done;     // finish the drain silently (foreign ID or verify error)
    logic [7:0]             r_err_cnt;
    logic                   r_load_done;
    logic                   r_load_err;
    logic                   r_tready;

    logic                   w_accept;
    logic                   w_hdr_accept;
    logic                   w_beat_in;
    logic                   w_id_ok;
    logic [HDR_CNT_W-1:0]   w_hdr_cnt;
    logic                   w_last_entry;
    logic                   w_last_beat;
    logic                   w_entry_valid;
    logic [ENTRY_W-1:0]     w_entry;
    logic                   w_cmp_ok;
    logic                   w_commit;
    logic                   w_mismatch;
    logic                   w_done_nxt;
    logic                   w_err_nxt;
    logic                   w_tready_nxt;
    logic                   w_rd_en_nxt;

    // tready is forced low while reset is asserted so nothing is accepted then.
    assign s_axis_tready = r_tready & ~axis_rst;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_hdr_accept  = w_accept && (r_state == ST_IDLE);
    assign w_beat_in     = w_accept && (r_state == ST_FILL);
    assign w_id_ok       = (s_axis_tdata[HDR_ID_LSB +: HDR_ID_W] == MODULE_ID);
    assign w_hdr_cnt     = clamp_count(s_axis_tdata[HDR_CNT_LSB +: HDR_CNT_W]);
    assign w_last_entry  = (r_remaining == 5'd1);

    // Where to go once an entry is fully committed (written, and verified if enabled).
    assign w_post_state  = r_last_seen  ? ST_IDLE  :
                           w_last_entry ? ST_DRAIN : ST_FILL;

`ifdef CFG_LOADER_READBACK_EN
    logic r_rd_en;

    assign w_cmp_ok    = (ram_rd_data == w_entry);
    assign w_commit    = (r_state == ST_VCMP) && w_cmp_ok;
    assign ram_rd_en   = r_rd_en;
    assign ram_rd_addr = r_addr;

    // Read strobe is registered from the next-state decode, so it is high exactly in VRD.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= w_rd_en_nxt;
        end
    end
`else
    logic w_unused_rd;

    assign w_cmp_ok    = 1'b1;
    assign w_commit    = (r_state == ST_WRITE);
    assign ram_rd_en   = 1'b0;
    assign ram_rd_addr = '0;
    assign w_unused_rd = ^ram_rd_data;
`endif

    assign w_mismatch = (r_state == ST_VCMP) && !w_cmp_ok;

    cfg_beat_packer #(
        .ENTRY_W (ENTRY_W),
        .DATA_W  (DATA_W),
        .BEATS   (BEATS)
    ) u_packer (
        .i_clk         (axis_clk),
        .i_rst         (axis_rst),
        .i_clear       (w_hdr_accept),
        .i_beat_valid  (w_beat_in),
        .i_beat        (s_axis_tdata),
        .o_last_beat   (w_last_beat),
        .o_entry_valid (w_entry_valid),
        .o_entry       (w_entry)
    );

    // The packer's completion pulse lands exactly in the WRITE cycle.
    assign ram_wr_en   = w_entry_valid;
    assign ram_wr_addr = r_addr;
    assign ram_wr_data = w_entry;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;
    assign err_cnt     = r_err_cnt;

    // FSM state register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // A single-beat packet has nothing left to drain.
                    if (!w_id_ok || (w_hdr_cnt == 5'd0)) begin
                        w_next_state = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        w_next_state = s_axis_tlast ? ST_IDLE : ST_FILL;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_accept && w_last_beat) begin
                    w_next_state = ST_WRITE;
                end else if (w_accept && s_axis_tlast) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_WRITE: begin
`ifdef CFG_LOADER_READBACK_EN
                w_next_state = ST_VRD;
`else
                w_next_state = w_post_state;
`endif
            end
            ST_VRD: begin
                w_next_state = ST_VCMP;
            end
            ST_VCMP: begin
                if (w_cmp_ok) begin
                    w_next_state = w_post_state;
                end else begin
                    w_next_state = r_last_seen ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: next values for the registered status outputs.
    always_comb begin
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_tready_nxt = (w_next_state == ST_IDLE) || (w_next_state == ST_FILL) ||
                       (w_next_state == ST_DRAIN);
        w_rd_en_nxt  = (w_next_state == ST_VRD);
        case (r_state)
            ST_IDLE: begin
                // Header-only packet: empty load is complete, a non-empty one is truncated.
                if (w_accept && w_id_ok && s_axis_tlast) begin
                    if (w_hdr_cnt == 5'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            ST_FILL: begin
                if (w_accept && s_axis_tlast && !w_last_beat) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b0;
                end
            end
            ST_WRITE, ST_VCMP: begin
                // Packet ended on an entry boundary: complete only if it was the last entry.
                if (w_commit && r_last_seen) begin
                    if (w_last_entry) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_mismatch) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (w_accept && s_axis_tlast && !r_no_done) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs; tready flop resets to 1 because the FSM resets to IDLE.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_tready    <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_tready    <= w_tready_nxt;
            r_load_done <= w_done_nxt;
            r_load_err  <= w_err_nxt;
        end
    end

    // Packet bookkeeping: write address, entries left, end-of-packet flags.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_last_seen <= 1'b0;
            r_no_done   <= 1'b0;
        end else if (w_hdr_accept) begin
            r_addr      <= s_axis_tdata[HDR_ADDR_LSB +: ADDR_W];
            r_remaining <= w_hdr_cnt;
            r_no_done   <= !w_id_ok;
        end else if (w_commit) begin
            r_addr      <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_remaining <= r_remaining - 5'd1;
        end else if (w_mismatch) begin
            r_no_done   <= 1'b1;
        end else if (w_beat_in && w_last_beat) begin
            r_last_seen <= s_axis_tlast;
        end else begin
            r_last_seen <= r_last_seen;
        end
    end

    // Saturating error counter.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_nxt) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

endmodule

// File: tb/tb_cfg_entry_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_entry_loader
// Randomized + directed packets against a packet-level reference model.
// When CFG_LOADER_READBACK_EN is defined the RAM model can corrupt bit 166 on
// readback.
// -----------------------------------------------------------------------------
module tb_cfg_entry_loader;

    localparam int ENTRY_W = 167;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 4;

    logic               axis_clk = 1'b0;
    logic               axis_rst = 1'b1;
    logic [DATA_W-1:0]  s_axis_tdata = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tlast = 1'b0;
    logic               s_axis_tready;
    logic               ram_wr_en;
    logic [ADDR_W-1:0]  ram_wr_addr;
    logic [ENTRY_W-1:0] ram_wr_data;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic [ENTRY_W-1:0] ram_rd_data = '0;
    logic               load_done;
    logic               load_err;
    logic [7:0]         err_cnt;

    always #5 axis_clk = ~axis_clk;

    cfg_entry_loader dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .load_done     (load_done),
        .load_err      (load_err),
        .err_cnt       (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model with registered read; optional corruption of the top bit.
    logic [ENTRY_W-1:0] mem [16];
    logic               corrupt = 1'b0;
    always @(posedge axis_clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr] ^ (corrupt ? {1'b1, {(ENTRY_W-1){1'b0}}} : {ENTRY_W{1'b0}});
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [ADDR_W-1:0]  got_addr [$];
    logic [ENTRY_W-1:0] got_data [$];
    int   got_done = 0, got_err = 0, got_rd = 0, bad_wr_timing = 0, tready_low = 0;
    logic prev_acc = 1'b0;
    always @(negedge axis_clk) begin
        if (ram_wr_en) begin
            got_addr.push_back(ram_wr_addr);
            got_data.push_back(ram_wr_data);
            if (!prev_acc) bad_wr_timing++;
        end
        if (load_done) got_done++;
        if (load_err)  got_err++;
        if (ram_rd_en) got_rd++;
        if (!s_axis_tready && !axis_rst) tready_low++;
        prev_acc = s_axis_tvalid && s_axis_tready;
    end

    // Packet under test and the model's expectations for it.
    logic [63:0]        pkt [$];
    logic [ADDR_W-1:0]  exp_addr [$];
    logic [ENTRY_W-1:0] exp_data [$];
    int                 exp_done, exp_err;
    int                 model_err_cnt = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic build_pkt(input logic [7:0] id, input logic [3:0] addr, input logic [4:0] cnt, input int nbeats);
        logic [63:0] h;
        pkt.delete();
        h = {$urandom(), $urandom()};
        h[7:0]   = id;
        h[11:8]  = addr;
        h[16:12] = cnt;
        pkt.push_back(h);
        for (int i = 1; i < nbeats; i++) pkt.push_back({$urandom(), $urandom()});
    endtask

    // Packet-level reference: how many whole entries arrived vs. how many were requested.
    task automatic model_pkt();
        logic [63:0]  h;
        logic [191:0] cat;
        int cnt, full, k;
        h = pkt[0];
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        if (h[7:0] != 8'h00) return;
        cnt  = int'(h[16:12]);
        if (cnt > 16) cnt = 16;
        full = (pkt.size() - 1) / 3;
        k    = (full < cnt) ? full : cnt;
        if (corrupt && k > 0) begin
            k = 1;
            exp_err = 1;
        end else if (full >= cnt) begin
            exp_done = 1;
        end else begin
            exp_err = 1;
        end
        for (int i = 0; i < k; i++) begin
            cat = {pkt[3*i+3], pkt[3*i+2], pkt[3*i+1]};
            exp_addr.push_back(ADDR_W'((int'(h[11:8]) + i) % 16));
            exp_data.push_back(cat[ENTRY_W-1:0]);
        end
        if (exp_err != 0 && model_err_cnt < 255) model_err_cnt++;
    endtask

    // Drive beats [first..last]; gap_pct chance of an idle cycle before each beat.
    task automatic send_beats(input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) begin
            bit acc;
            int t;
            if ($urandom_range(0, 99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                idle(1);
            end
            s_axis_tdata  = pkt[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == pkt.size() - 1);
            acc = 1'b0;
            t   = 0;
            while (!acc && t <= 64) begin
                @(negedge axis_clk);
                acc = s_axis_tready;
                @(posedge axis_clk);
                #1;
                t++;
            end
            if (!acc) begin
                check_eq("accept_timeout", 192'(1), 192'(0));
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input int gap_pct);
        int base_wr, base_done, base_err, n;
        model_pkt();
        base_wr   = got_addr.size();
        base_done = got_done;
        base_err  = got_err;
        send_beats(0, pkt.size() - 1, gap_pct);
        idle(10);
        n = got_addr.size() - base_wr;
        check_eq({tag, ".nwr"}, 192'(n), 192'(exp_addr.size()));
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            check_eq($sformatf("%s.addr%0d", tag, i), 192'(got_addr[base_wr+i]), 192'(exp_addr[i]));
            check_eq($sformatf("%s.data%0d", tag, i), 192'(got_data[base_wr+i]), 192'(exp_data[i]));
        end
        check_eq({tag, ".done"}, 192'(got_done - base_done), 192'(exp_done));
        check_eq({tag, ".err"}, 192'(got_err - base_err), 192'(exp_err));
        check_eq({tag, ".errcnt"}, 192'(err_cnt), 192'(model_err_cnt));
        @(negedge axis_clk);
        check_eq({tag, ".tready"}, 192'(s_axis_tready), 192'(1));
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        int base_low, base_wr, cnt, mode, nb;
        logic [7:0] id;

        // Reset values
        idle(3);
        @(negedge axis_clk);
        check_eq("rst.tready", 192'(s_axis_tready), 192'(0));
        check_eq("rst.wr_en", 192'(ram_wr_en), 192'(0));
        check_eq("rst.rd_en", 192'(ram_rd_en), 192'(0));
        check_eq("rst.done", 192'(load_done), 192'(0));
        check_eq("rst.err", 192'(load_err), 192'(0));
        check_eq("rst.errcnt", 192'(err_cnt), 192'(0));
        @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
        @(negedge axis_clk);
        check_eq("post_rst.tready", 192'(s_axis_tready), 192'(1));
        @(posedge axis_clk);
        #1;

        // Basic two-entry load
        build_pkt(8'h00, 4'd2, 5'd2, 7);
        run_pkt("t1", 0);

        // Foreign module ID is drained silently, then a good packet loads
        build_pkt(8'h05, 4'd0, 5'd1, 4);
        base_low = tready_low;
        run_pkt("t2", 0);
        check_eq("t2.tready_high", 192'(tready_low - base_low), 192'(0));
        build_pkt(8'h00, 4'd7, 5'd1, 4);
        run_pkt("t2b", 0);

        // Address wraps from 15 to 0
        build_pkt(8'h00, 4'd15, 5'd2, 7);
        run_pkt("t3", 0);

        // Truncated: tlast on 4th beat of a 2-entry packet
        build_pkt(8'h00, 4'd0, 5'd2, 4);
        run_pkt("t4", 0);
        check_eq("t4.errcnt1", 192'(err_cnt), 192'(1));

        // Empty load with and without trailing beats
        build_pkt(8'h00, 4'd3, 5'd0, 1);
        run_pkt("t5a", 0);
        build_pkt(8'h00, 4'd3, 5'd0, 3);
        run_pkt("t5b", 0);

`ifdef CFG_LOADER_READBACK_EN
        // Verify mismatch: one write, error, drain to tlast, then normal operation
        corrupt = 1'b1;
        build_pkt(8'h00, 4'd3, 5'd2, 9);
        run_pkt("rb_bad", 0);
        corrupt = 1'b0;
        build_pkt(8'h00, 4'd3, 5'd2, 7);
        run_pkt("rb_ok", 0);
`endif

        // Count field above 16 is clamped; extra beats drained
        build_pkt(8'h00, 4'd5, 5'd23, 1 + 48 + 2);
        run_pkt("clamp", 20);

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            id   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            cnt  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            if (mode == 1 && cnt > 0) nb = $urandom_range(1, 3 * ((cnt > 16) ? 16 : cnt));
            else if (mode == 2)       nb = 1 + 3 * ((cnt > 16) ? 16 : cnt) + $urandom_range(1, 4);
            else                      nb = 1 + 3 * ((cnt > 16) ? 16 : cnt);
            build_pkt(id, 4'($urandom_range(0, 15)), 5'(cnt), nb);
            run_pkt($sformatf("rnd%0d", p), 30);
        end

        // Error counter saturation
        for (int p = 0; p < 260; p++) begin
            build_pkt(8'h00, 4'd0, 5'd1, 1);
            model_pkt();
            send_beats(0, 0, 0);
            idle(2);
        end
        idle(4);
        check_eq("sat.errcnt", 192'(err_cnt), 192'(255));
        check_eq("sat.model", 192'(err_cnt), 192'(model_err_cnt));

        // Reset in the middle of FILL with tvalid toggling
        build_pkt(8'h00, 4'd1, 5'd2, 7);
        base_wr = got_addr.size();
        send_beats(0, 2, 100);
        s_axis_tdata  = pkt[3];
        s_axis_tvalid = 1'b1;
        axis_rst      = 1'b1;
        @(posedge axis_clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge axis_clk);
            check_eq($sformatf("mrst%0d.tready", c), 192'(s_axis_tready), 192'(0));
            check_eq($sformatf("mrst%0d.wr_en", c), 192'(ram_wr_en), 192'(0));
            check_eq($sformatf("mrst%0d.done", c), 192'(load_done), 192'(0));
            check_eq($sformatf("mrst%0d.err", c), 192'(load_err), 192'(0));
            check_eq($sformatf("mrst%0d.errcnt", c), 192'(err_cnt), 192'(0));
            check_eq($sformatf("mrst%0d.rd_en", c), 192'(ram_rd_en), 192'(0));
            @(posedge axis_clk);
            #1;
            s_axis_tvalid = ~s_axis_tvalid;
        end
        axis_rst      = 1'b0;
        s_axis_tvalid = 1'b0;
        model_err_cnt = 0;
        @(negedge axis_clk);
        check_eq("mrst.tready_after", 192'(s_axis_tready), 192'(1));
        @(posedge axis_clk);
        #1;
        idle(6);
        check_eq("mrst.no_write", 192'(got_addr.size() - base_wr), 192'(0));
        build_pkt(8'h00, 4'd9, 5'd1, 4);
        run_pkt("after_rst", 0);

        check_eq("wr_timing", 192'(bad_wr_timing), 192'(0));
`ifndef CFG_LOADER_READBACK_EN
        check_eq("no_rd_en", 192'(got_rd), 192'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
